// File: rtl/gr_pkg.sv
// Shared types and constants for the global register controller: field widths,
// read-back record layout, error flags and the power-on register defaults.
package gr_pkg;

   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 16;
   localparam int GR_NREG = 36;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rb_entry_t;

   typedef struct packed {
      logic addr;
      logic run;
   } gr_err_t;

   localparam logic [DATA_W-1:0] REG_DEFAULT [GR_NREG] = '{
      0:  16'h0001,
      1:  16'h8000,
      2:  16'h00FF,
      3:  16'h0C3C,
      5:  16'h1234,
      7:  16'h4000,
      35: 16'hBEEF,
      default: 16'h0000
   };

   // Addresses beyond the default table fall back to zero
   function automatic logic [DATA_W-1:0] reg_default(input int idx);
      logic [DATA_W-1:0] v;
      v = 16'h0000;
      if (idx >= 0 && idx < GR_NREG) begin
         v = REG_DEFAULT[idx];
      end
      return v;
   endfunction

endpackage

// File: rtl/gr_rb_fifo.sv
// First-word-fall-through synchronous FIFO holding read-back records; the head
// entry is visible whenever the FIFO is not empty.
module gr_rb_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wp_r;
   logic [PW-1:0]    rp_r;
   logic [PW:0]      cnt_r;
   logic             pop_ok_s;
   logic             push_ok_s;

   // A push into a full FIFO is still taken when a pop frees a slot in the same cycle
   always_comb begin
      empty     = (cnt_r == {(PW+1){1'b0}});
      full      = (cnt_r == DEPTH_L);
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
      head      = mem_r[rp_r];
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wp_r] <= push_data;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_r  <= {PW{1'b0}};
         rp_r  <= {PW{1'b0}};
         cnt_r <= {(PW+1){1'b0}};
      end else begin
         if (push_ok_s) wp_r <= wp_r + {{(PW-1){1'b0}}, 1'b1};
         if (pop_ok_s)  rp_r <= rp_r + {{(PW-1){1'b0}}, 1'b1};
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_r <= cnt_r + {{PW{1'b0}}, 1'b1};
            2'b01:   cnt_r <= cnt_r - {{PW{1'b0}}, 1'b1};
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/global_reg_ctrl.sv
// Global configuration register file and RunMode flag driven by the decoder's
// slow-command strobes, with a read-back FIFO toward the output formatter.
module global_reg_ctrl
   import gr_pkg::*;
#(
   parameter int NREG     = GR_NREG,
   parameter int RB_DEPTH = 4,
   parameter int WR_ALIGN = 2,
   parameter int RD_ALIGN = 2
) (
   input  logic               CK,
   input  logic               Rst,
   input  logic               DataIn,
   input  logic               WrReg,
   input  logic               RdReg,
   input  logic               ResetCmd,
   input  logic               SetRunMode,
   input  logic               ClrRunMode,
   output logic [NREG*16-1:0] GlobalCfg,
   output logic               RunMode,
   output logic               RbValid,
   output logic [21:0]        RbData,
   input  logic               RbReady,
   output logic               RbOvfl,
   output logic               ErrAddr,
   output logic               ErrRun
);

   localparam int SH_W = 22 + ((WR_ALIGN > RD_ALIGN) ? WR_ALIGN : RD_ALIGN);
   localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

   logic [SH_W-1:0]   sh_r;
   logic              wr_d_r;
   logic [DATA_W-1:0] regs_r [NREG];
   logic              run_r;
   gr_err_t           err_r;
   logic              ovfl_r;

   logic              wr_rise_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] wdata_s;
   logic [ADDR_W-1:0] raddr_s;
   logic [DATA_W-1:0] rdata_s;
   logic              waddr_ok_s;
   logic              raddr_ok_s;
   logic              wr_take_s;
   logic              wr_en_s;
   gr_err_t           err_s;
   rb_entry_t         push_ent_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [21:0]       head_s;

   // Command decode; ResetCmd swallows a coincident write without raising an error
   always_comb begin
      wr_rise_s  = WrReg & ~wr_d_r;
      waddr_s    = sh_r[WR_ALIGN+21:WR_ALIGN+16];
      wdata_s    = sh_r[WR_ALIGN+15:WR_ALIGN];
      raddr_s    = sh_r[RD_ALIGN+5:RD_ALIGN];
      waddr_ok_s = ({1'b0, waddr_s} < NREG_L);
      raddr_ok_s = ({1'b0, raddr_s} < NREG_L);
      if (raddr_ok_s) begin
         rdata_s = regs_r[raddr_s];
      end else begin
         rdata_s = 16'h0000;
      end
      wr_take_s       = wr_rise_s & ~ResetCmd;
      wr_en_s         = wr_take_s & ~run_r & waddr_ok_s;
      err_s.run       = wr_take_s & run_r;
      err_s.addr      = (wr_take_s & ~run_r & ~waddr_ok_s) | (RdReg & ~raddr_ok_s);
      push_ent_s.addr = raddr_s;
      push_ent_s.data = rdata_s;
      pop_s           = RbReady & ~empty_s;
   end

   // Shifter, register file, RunMode and error pulse state
   always_ff @(posedge CK) begin
      if (Rst) begin
         sh_r   <= {SH_W{1'b0}};
         wr_d_r <= 1'b0;
         run_r  <= 1'b0;
         err_r  <= '0;
         ovfl_r <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_r[i] <= reg_default(i);
      end else begin
         sh_r   <= {sh_r[SH_W-2:0], DataIn};
         wr_d_r <= WrReg;
         err_r  <= err_s;
         ovfl_r <= RdReg & full_s & ~pop_s;
         if (ResetCmd) begin
            for (int i = 0; i < NREG; i++) regs_r[i] <= reg_default(i);
         end else if (wr_en_s) begin
            regs_r[waddr_s] <= wdata_s;
         end
         if (ResetCmd | ClrRunMode) begin
            run_r <= 1'b0;
         end else if (SetRunMode) begin
            run_r <= 1'b1;
         end
      end
   end

   gr_rb_fifo #(
      .WIDTH (22),
      .DEPTH (RB_DEPTH)
   ) u_rb_fifo (
      .clk       (CK),
      .rst       (Rst),
      .push      (RdReg),
      .push_data (push_ent_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   for (genvar g = 0; g < NREG; g++) begin : g_cfg
      assign GlobalCfg[16*g +: 16] = regs_r[g];
   end

   assign RunMode = run_r;
   assign RbValid = ~empty_s;
   assign RbData  = empty_s ? 22'h000000 : head_s;
   assign RbOvfl  = ovfl_r;
   assign ErrAddr = err_r.addr;
   assign ErrRun  = err_r.run;

endmodule

// File: tb/tb_global_reg_ctrl.sv
// Scoreboard bench for global_reg_ctrl: a behavioural model predicts every edge,
// a negedge monitor compares outputs and pops read-back records on handshakes.
module tb_global_reg_ctrl;
   import gr_pkg::*;

   localparam int NREG = 36;
   localparam int RB_DEPTH = 4;
   localparam int WR_ALIGN = 2;
   localparam int RD_ALIGN = 2;
   localparam int CW = NREG*16;

   logic CK;
   logic Rst, DataIn, WrReg, RdReg, ResetCmd, SetRunMode, ClrRunMode, RbReady;
   logic [CW-1:0] GlobalCfg;
   logic RunMode, RbValid, RbOvfl, ErrAddr, ErrRun;
   logic [21:0] RbData;

   global_reg_ctrl #(.NREG(NREG), .RB_DEPTH(RB_DEPTH), .WR_ALIGN(WR_ALIGN), .RD_ALIGN(RD_ALIGN)) dut (
      .CK(CK), .Rst(Rst), .DataIn(DataIn), .WrReg(WrReg), .RdReg(RdReg),
      .ResetCmd(ResetCmd), .SetRunMode(SetRunMode), .ClrRunMode(ClrRunMode),
      .GlobalCfg(GlobalCfg), .RunMode(RunMode), .RbValid(RbValid), .RbData(RbData),
      .RbReady(RbReady), .RbOvfl(RbOvfl), .ErrAddr(ErrAddr), .ErrRun(ErrRun)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   typedef struct {
      logic [CW-1:0] cfg;
      bit run, valid, ea, er, ov, zero_data;
   } exp_t;

   int n_vec = 0;
   int n_bad = 0;
   exp_t exp_q[$];
   logic [21:0] sb_q[$];

   // reference model state
   logic [15:0] mregs [NREG];
   bit mrun, mwr_d;
   bit hist[$];
   logic [21:0] mq[$];
   bit rb_ready = 1'b0;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic int unsigned shf(input int lo, input int w);
      int unsigned v = 0;
      for (int k = lo + w - 1; k >= lo; k--) begin
         v = (v << 1) | ((k < hist.size()) ? int'(hist[hist.size()-1-k]) : 0);
      end
      return v;
   endfunction

   function automatic logic [CW-1:0] default_cfg();
      logic [CW-1:0] v;
      for (int i = 0; i < NREG; i++) v[16*i +: 16] = REG_DEFAULT[i];
      return v;
   endfunction

   // One clock: apply inputs, predict the edge, then hand expectations to the monitor
   task automatic step(input bit wr, input bit rd, input bit rc, input bit st, input bit cl,
                       input bit din, input bit rs);
      exp_t e;
      logic [21:0] ent;
      bit do_push = 0, do_flush = 0;
      Rst = rs; WrReg = wr; RdReg = rd; ResetCmd = rc;
      SetRunMode = st; ClrRunMode = cl; DataIn = din; RbReady = rb_ready;
      e.ea = 0; e.er = 0; e.ov = 0; e.zero_data = 0;
      ent = '0;
      if (rs) begin
         for (int i = 0; i < NREG; i++) mregs[i] = REG_DEFAULT[i];
         mrun = 0; mwr_d = 0; mq.delete(); hist.delete();
         do_flush = 1; e.zero_data = 1;
      end else begin
         bit pop, rise;
         int unsigned waddr, wdata, raddr;
         pop   = rb_ready && mq.size() > 0;
         rise  = wr && !mwr_d;
         waddr = shf(WR_ALIGN + 16, 6);
         wdata = shf(WR_ALIGN, 16);
         raddr = shf(RD_ALIGN, 6);
         if (rd) begin
            ent[21:16] = raddr[5:0];
            ent[15:0]  = (raddr < NREG) ? mregs[raddr] : 16'h0000;
            if (raddr >= NREG) e.ea = 1;
            if (mq.size() < RB_DEPTH || pop) do_push = 1;
            else e.ov = 1;
         end
         if (pop) void'(mq.pop_front());
         if (do_push) mq.push_back(ent);
         if (rise && !rc) begin
            if (mrun) e.er = 1;
            else if (waddr >= NREG) e.ea = 1;
            else mregs[waddr] = wdata[15:0];
         end
         if (rc) begin
            for (int i = 0; i < NREG; i++) mregs[i] = REG_DEFAULT[i];
            mrun = 0;
         end else if (cl) mrun = 0;
         else if (st) mrun = 1;
         mwr_d = wr;
         hist.push_back(din);
         if (hist.size() > 40) void'(hist.pop_front());
      end
      for (int i = 0; i < NREG; i++) e.cfg[16*i +: 16] = mregs[i];
      e.run = mrun;
      e.valid = (mq.size() > 0);
      @(posedge CK);
      if (do_flush) sb_q.delete();
      if (do_push) sb_q.push_back(ent);
      exp_q.push_back(e);
      #1;
   endtask

   // Outputs are checked mid-cycle, well away from the sampling edge
   always @(negedge CK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("GlobalCfg", GlobalCfg, e.cfg);
         chk("RunMode", CW'(RunMode), CW'(e.run));
         chk("RbValid", CW'(RbValid), CW'(e.valid));
         chk("ErrAddr", CW'(ErrAddr), CW'(e.ea));
         chk("ErrRun", CW'(ErrRun), CW'(e.er));
         chk("RbOvfl", CW'(RbOvfl), CW'(e.ov));
         if (e.zero_data) chk("RbData_after_rst", CW'(RbData), '0);
      end
      if (RbValid === 1'b1 && RbReady === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL RbData_unexpected: got %0h expected no entry", RbData);
         end else begin
            logic [21:0] x;
            x = sb_q.pop_front();
            chk("RbData", CW'(RbData), CW'(x));
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1'($urandom), 0);
   endtask

   task automatic send_bits(input logic [21:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(0, 0, 0, 0, 0, v[i], 0);
   endtask

   task automatic send_frame(input logic [5:0] a, input logic [15:0] d);
      send_bits({a, d}, 22);
      send_bits(22'($urandom), WR_ALIGN);
   endtask

   task automatic wr_cmd(input logic [5:0] a, input logic [15:0] d);
      send_frame(a, d);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1'($urandom), 0);
      idle(1);
   endtask

   task automatic rd_cmd(input logic [5:0] a);
      send_bits({16'h0000, a}, 6);
      send_bits(22'($urandom), RD_ALIGN);
      step(0, 1, 0, 0, 0, 1'($urandom), 0);
   endtask

   initial begin
      Rst = 1; DataIn = 0; WrReg = 0; RdReg = 0; ResetCmd = 0;
      SetRunMode = 0; ClrRunMode = 0; RbReady = 0;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("reset_cfg_direct", GlobalCfg, default_cfg());
      idle(2);

      // basic write then read-back
      wr_cmd(6'd5, 16'hA5C3);
      chk("reg5_direct", CW'(GlobalCfg[95:80]), CW'(16'hA5C3));
      rb_ready = 0;
      rd_cmd(6'd5);
      chk("rb_valid_direct", CW'(RbValid), CW'(1'b1));
      chk("rb_data_direct", CW'(RbData), CW'({6'd5, 16'hA5C3}));
      rb_ready = 1;
      idle(1);
      chk("rb_empty_direct", CW'(RbValid), CW'(1'b0));

      // fill FIFO, overflow on the fifth read, then drain
      rb_ready = 0;
      for (int i = 0; i < 4; i++) rd_cmd(6'(i));
      rd_cmd(6'd4);
      chk("ovfl_direct", CW'(RbOvfl), CW'(1'b1));
      idle(1);
      rb_ready = 1;
      idle(6);

      // RunMode blocks writes; clear wins; out-of-range address
      step(0, 0, 0, 1, 0, 0, 0);
      wr_cmd(6'd3, 16'h1111);
      chk("reg3_kept_direct", CW'(GlobalCfg[63:48]), CW'(REG_DEFAULT[3]));
      step(0, 0, 0, 1, 1, 0, 0);
      chk("clr_wins_direct", CW'(RunMode), CW'(1'b0));
      wr_cmd(6'd40, 16'h7777);

      // ResetCmd coincident with a write, FIFO kept
      wr_cmd(6'd7, 16'hBEEF);
      rb_ready = 0;
      rd_cmd(6'd7);
      rd_cmd(6'd5);
      send_frame(6'd8, 16'h5555);
      step(1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
      chk("resetcmd_cfg_direct", GlobalCfg, default_cfg());
      rb_ready = 1;
      idle(4);

      // Rst mid-WrReg with two entries queued
      rb_ready = 0;
      wr_cmd(6'd9, 16'h0F0F);
      rd_cmd(6'd9);
      rd_cmd(6'd1);
      send_frame(6'd10, 16'h3333);
      step(1, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1);
      chk("rst_valid_direct", CW'(RbValid), CW'(1'b0));
      chk("rst_cfg_direct", GlobalCfg, default_cfg());
      idle(2);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         int op;
         rb_ready = ($urandom_range(0, 2) != 0);
         op = $urandom_range(0, 10);
         case (op)
            0, 1, 2, 3: wr_cmd(6'($urandom_range(0, 45)), 16'($urandom));
            4, 5, 6:    rd_cmd(6'($urandom_range(0, 45)));
            7:          step(0, 0, 0, 1, 0, 1'($urandom), 0);
            8:          step(0, 0, 0, 0, 1, 1'($urandom), 0);
            9:          step(0, 0, 0, 1, 1, 1'($urandom), 0);
            default:    step(0, 0, 1, 0, 0, 1'($urandom), 0);
         endcase
      end
      rb_ready = 1;
      idle(8);
      @(negedge CK);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/global_reg_ctrl.md
Name: global_reg_ctrl

Overview:
- Sits directly downstream of the command decoder FSM.
- Consumes its registered slow-command strobes (WrReg, RdReg, Reset, SetRunMode, ClrRunMode) together with the serial command bit stream.
- Owns the global configuration register file and the RunMode flag.
- Queues read-back records (address + data) in a small FIFO toward the data-output formatter.

Parameters:
- NREG, 36, number of implemented 16-bit global registers (addresses 0..NREG-1).
- RB_DEPTH, 4, read-back FIFO depth (power of 2, >=2).
- WR_ALIGN, 2, bits shifted after the last data bit by the cycle WrReg first samples high.
- RD_ALIGN, 2, bits shifted after the last address bit by the cycle RdReg samples high.

Ports:
- CK  in  1  clock; all logic on posedge.
- Rst  in  1  synchronous reset, active-high.
- DataIn  in  1  serial command bit, same bit that enters the decoder shift register, MSB first.
- WrReg  in  1  write strobe from decoder, 4 cycles wide, already chip-selected.
- RdReg  in  1  read strobe from decoder, 1 cycle, already chip-selected.
- ResetCmd  in  1  global-reset command strobe from decoder.
- SetRunMode  in  1  set-RunMode strobe.
- ClrRunMode  in  1  clear-RunMode strobe.
- GlobalCfg  out  NREG*16  flat register contents; register n sits in bits [16n+15:16n].
- RunMode  out  1  run-mode flag.
- RbValid  out  1  read-back FIFO not empty.
- RbData  out  22  head entry, {addr[5:0], data[15:0]}.
- RbReady  in  1  consumer pop; a pop occurs when RbValid & RbReady.
- RbOvfl  out  1  1-cycle pulse: RdReg dropped because the FIFO was full.
- ErrAddr  out  1  1-cycle pulse: write or read to an address >= NREG.
- ErrRun  out  1  1-cycle pulse: write attempted while RunMode=1.

Behaviour:
- Shifter:
  - sh has width 22+max(WR_ALIGN,RD_ALIGN).
  - Updates every cycle: sh <= {sh[W-2:0], DataIn}.
  - Not reset-dependent for function; cleared on Rst.
- Write capture:
  - wr_rise = WrReg & ~WrReg_d; WrReg_d is a 1-bit register.
  - addr = sh[WR_ALIGN+21:WR_ALIGN+16]; data = sh[WR_ALIGN+15:WR_ALIGN].
  - The register updates at the edge sampling wr_rise, so GlobalCfg shows the new value from the next cycle.
  - The remaining 3 WrReg cycles are ignored.
- Write filtering:
  - addr >= NREG: no write, ErrAddr=1 for one cycle.
  - RunMode=1: no write, ErrRun=1.
  - If both conditions hold, only ErrRun pulses.
- Read:
  - On RdReg=1: raddr = sh[RD_ALIGN+5:RD_ALIGN].
  - Entry {raddr, reg[raddr]} is pushed, or {raddr, 16'h0000} plus ErrAddr if raddr >= NREG.
  - Reads are allowed in RunMode.
  - RbValid rises the cycle after the push when the FIFO was empty.
- FIFO:
  - RB_DEPTH entries, first-word-fall-through.
  - Push and pop in the same cycle while full are both accepted; the count is unchanged and no overflow occurs.
  - Push while full and no pop: entry dropped, RbOvfl pulses.
- RunMode:
  - SetRunMode sets the flag; ClrRunMode clears it.
  - Both asserted in the same cycle: clear wins.
  - Updates at the strobe edge.
- ResetCmd:
  - All registers load REG_DEFAULT at the strobe edge.
  - RunMode cleared; the FIFO is NOT flushed.
  - ResetCmd coincident with wr_rise: the reset wins and the write is discarded (no error pulse).
- Read/write collision: RdReg and wr_rise in the same cycle returns the pre-write value.
- Rst (any time, including mid-WrReg or with the FIFO non-empty):
  - Registers return to REG_DEFAULT; RunMode=0.
  - FIFO emptied, so RbValid=0 and RbData=0.
  - RbOvfl=ErrAddr=ErrRun=0; WrReg_d=0; sh=0.
  - A WrReg still high after Rst deasserts counts as a rising edge only if WrReg_d=0, which is the case after Rst. The decoder is reset together, so this is benign.
- Reset values of outputs:
  - GlobalCfg = REG_DEFAULT.
  - All other outputs 0.

Decomposition:
- Package gr_pkg:
  - constants ADDR_W=6, DATA_W=16.
  - typedef rb_entry_t (packed {addr, data}).
  - REG_DEFAULT array [NREG] of 16-bit values.
  - typedef gr_err_t.
- Sub-module gr_rb_fifo: parameterized sync FIFO with push/pop/full/empty, instantiated once.

Test Plan:
- Serial addr 6'd5, data 16'hA5C3, then WrReg high 4 cycles with WR_ALIGN=2 -> GlobalCfg[95:80]=16'hA5C3 one cycle after the WrReg rise; exactly one write, no error pulses.
- Then serial addr 6'd5 plus RdReg pulse -> RbValid next cycle, RbData={6'd5,16'hA5C3}; RbReady=1 pops it, RbValid=0 the cycle after.
- Four reads with RbReady=0 fill the FIFO; fifth RdReg -> RbOvfl one-cycle pulse; the four entries drain in order.
- SetRunMode, then a write to addr 3 -> ErrRun pulse, reg3 unchanged. SetRunMode+ClrRunMode in the same cycle -> RunMode=0. Write to addr 40 -> ErrAddr, no register changes.
- Registers modified, then ResetCmd coincident with wr_rise -> all REG_DEFAULT, write discarded, FIFO contents kept.
- Rst asserted mid-WrReg pulse with 2 FIFO entries -> next cycle RbValid=0, GlobalCfg=REG_DEFAULT, RunMode=0.
